// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the frame-buffer BRAM write arbiter.
package bram_arb_pkg;

   // Controller states: normal arbitration, or the built-in clear sweep
   typedef enum logic {
      ARB   = 1'b0,
      CLEAR = 1'b1
   } state_t;

   localparam int unsigned DROP_CNT_W = 16;

   // Smallest address width able to index 'depth' words (minimum 1)
   function automatic int unsigned addr_w(input int unsigned depth);
      int unsigned w;
      w = 1;
      while ((64'd1 << w) < 64'(depth)) w++;
      return w;
   endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant: a lone requester always wins; on a tie the
// requester that was not granted last time wins.
module rr_arbiter_2 (
   input  logic [1:0] valid,
   input  logic       last_grant,
   output logic [1:0] grant
);

   // Tie goes to requester 0 when requester 1 was granted last, and vice versa
   always_comb begin
      grant[0] = valid[0] & (~valid[1] | last_grant);
      grant[1] = valid[1] & (~valid[0] | ~last_grant);
   end

endmodule

// File: rtl/bram_write_arbiter.sv
// Shares the frame-buffer BRAM write port A between two valid/ready
// requesters with round-robin arbitration and a registered BRAM drive.
// Optional clear sweep compiled in with macro BRAM_CLEAR_EN.
module bram_write_arbiter
   import bram_arb_pkg::*;
#(
   parameter  int unsigned RAM_WIDTH = 16,
   parameter  int unsigned RAM_DEPTH = 76800,
   localparam int unsigned ADDR_W    = addr_w(RAM_DEPTH)
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  req0_valid_in,
   input  logic [ADDR_W-1:0]     req0_addr_in,
   input  logic [RAM_WIDTH-1:0]  req0_data_in,
   output logic                  req0_ready_out,
   input  logic                  req1_valid_in,
   input  logic [ADDR_W-1:0]     req1_addr_in,
   input  logic [RAM_WIDTH-1:0]  req1_data_in,
   output logic                  req1_ready_out,
   input  logic                  clear_start_in,
   input  logic [RAM_WIDTH-1:0]  clear_value_in,
   output logic                  clear_busy_out,
   output logic                  ena_out,
   output logic                  wea_out,
   output logic [ADDR_W-1:0]     addra_out,
   output logic [RAM_WIDTH-1:0]  dia_out,
   output logic [DROP_CNT_W-1:0] drop_count_out
);

   logic [1:0]           grant;
   logic                 last_grant;
   logic                 arb_open;
   logic                 xfer;
   logic                 in_range;
   logic [ADDR_W-1:0]    sel_addr;
   logic [RAM_WIDTH-1:0] sel_data;
   logic                 sweep_wr;
   logic [ADDR_W-1:0]    sweep_addr;
   logic [RAM_WIDTH-1:0] sweep_data;

   rr_arbiter_2 u_rr (
      .valid      ({req1_valid_in, req0_valid_in}),
      .last_grant (last_grant),
      .grant      (grant)
   );

`ifdef BRAM_CLEAR_EN
   state_t               state;
   state_t               state_nx;
   logic [ADDR_W-1:0]    sweep_cnt;
   logic [RAM_WIDTH-1:0] clear_val;
   logic                 sweep_last;

   assign sweep_last     = (sweep_cnt == ADDR_W'(RAM_DEPTH - 1));
   assign sweep_wr       = (state == CLEAR);
   assign sweep_addr     = sweep_cnt;
   assign sweep_data     = clear_val;
   assign clear_busy_out = (state == CLEAR);

   // State register
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) state <= ARB;
      else        state <= state_nx;
   end

   // Next state; a start request pre-empts arbitration for that cycle
   always_comb begin
      state_nx = state;
      arb_open = 1'b0;
      case (state)
         ARB: begin
            if (clear_start_in) state_nx = CLEAR;
            else                arb_open = 1'b1;
         end
         CLEAR: begin
            if (sweep_last) state_nx = ARB;
         end
         default: state_nx = ARB;
      endcase
   end

   // Sweep address counter and latched fill value
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         sweep_cnt <= '0;
         clear_val <= '0;
      end else if (state == ARB && clear_start_in) begin
         sweep_cnt <= '0;
         clear_val <= clear_value_in;
      end else if (state == CLEAR) begin
         sweep_cnt <= sweep_cnt + ADDR_W'(1);
      end
   end
`else
   logic unused_clear;

   assign unused_clear   = clear_start_in ^ (^clear_value_in);
   assign arb_open       = 1'b1;
   assign sweep_wr       = 1'b0;
   assign sweep_addr     = '0;
   assign sweep_data     = '0;
   assign clear_busy_out = 1'b0;
`endif

   assign req0_ready_out = arb_open & grant[0];
   assign req1_ready_out = arb_open & grant[1];
   assign xfer           = arb_open & (|grant);
   assign sel_addr       = grant[1] ? req1_addr_in : req0_addr_in;
   assign sel_data       = grant[1] ? req1_data_in : req0_data_in;
   assign in_range       = ({1'b0, sel_addr} < (ADDR_W + 1)'(RAM_DEPTH));

   // Registered BRAM drive, round-robin pointer and saturating drop counter
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         ena_out        <= 1'b0;
         wea_out        <= 1'b0;
         addra_out      <= '0;
         dia_out        <= '0;
         drop_count_out <= '0;
         last_grant     <= 1'b1;
      end else begin
         ena_out <= 1'b0;
         wea_out <= 1'b0;
         if (sweep_wr) begin
            ena_out   <= 1'b1;
            wea_out   <= 1'b1;
            addra_out <= sweep_addr;
            dia_out   <= sweep_data;
         end else if (xfer) begin
            last_grant <= grant[1];
            if (in_range) begin
               ena_out   <= 1'b1;
               wea_out   <= 1'b1;
               addra_out <= sel_addr;
               dia_out   <= sel_data;
            end else if (drop_count_out != '1) begin
               drop_count_out <= drop_count_out + DROP_CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_bram_write_arbiter.sv
// Scoreboard bench for bram_write_arbiter: the driver predicts readys,
// busy and drop count per cycle and queues expected BRAM writes with their
// due cycle; a negedge monitor pops and compares every BRAM write.
// Clear-sweep scenarios run when BRAM_CLEAR_EN is defined.
module tb_bram_write_arbiter;

   localparam int unsigned W  = 16;
   localparam int unsigned D  = 76800;
   localparam int unsigned AW = 17;
`ifdef BRAM_CLEAR_EN
   localparam bit CLEAR_EN = 1'b1;
`else
   localparam bit CLEAR_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          v0 = 1'b0, v1 = 1'b0, cs = 1'b0;
   logic [AW-1:0] a0 = '0, a1 = '0;
   logic [W-1:0]  d0 = '0, d1 = '0, cv = '0;
   logic          r0, r1, busy, ena, wea;
   logic [AW-1:0] addra;
   logic [W-1:0]  dia;
   logic [15:0]   drop;

   bram_write_arbiter #(.RAM_WIDTH(W), .RAM_DEPTH(D)) dut (
      .clk_in         (clk),
      .rst_in         (rst),
      .req0_valid_in  (v0),
      .req0_addr_in   (a0),
      .req0_data_in   (d0),
      .req0_ready_out (r0),
      .req1_valid_in  (v1),
      .req1_addr_in   (a1),
      .req1_data_in   (d1),
      .req1_ready_out (r1),
      .clear_start_in (cs),
      .clear_value_in (cv),
      .clear_busy_out (busy),
      .ena_out        (ena),
      .wea_out        (wea),
      .addra_out      (addra),
      .dia_out        (dia),
      .drop_count_out (drop)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned   due;
      logic [AW-1:0] addr;
      logic [W-1:0]  data;
   } wr_t;

   wr_t         q[$];
   wr_t         mon_w;
   int          nvec = 0;
   int          nerr = 0;

   // Reference model state
   bit          m_last = 1'b1;
   int unsigned clear_left = 0;
   logic [15:0] exp_drop = '0;
   bit          acc0, acc1;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Monitor: every BRAM write must match the head of the scoreboard on its due cycle
   always @(negedge clk) begin
      if (!rst) begin
         chk("wea_eq_ena", wea, ena);
         if (ena) begin
            if (q.size() == 0) begin
               nvec++;
               nerr++;
               $display("FAIL unexpected_write: got addr %0h data %0h, expected no write (cycle %0d)", addra, dia, cyc);
            end else begin
               mon_w = q.pop_front();
               chk("write_cycle", cyc, mon_w.due);
               chk("write_addr", addra, mon_w.addr);
               chk("write_data", dia, mon_w.data);
            end
         end else if (q.size() != 0 && q[0].due <= cyc) begin
            nvec++;
            nerr++;
            $display("FAIL missing_write: got none, expected addr %0h data %0h due %0d (cycle %0d)", q[0].addr, q[0].data, q[0].due, cyc);
            void'(q.pop_front());
         end
      end
   end

   // One cycle: check at negedge against the model, then advance past posedge
   task automatic step();
      bit  e0, e1;
      wr_t w;
      @(negedge clk);
      chk("clear_busy", busy, clear_left > 0);
      chk("drop_count", drop, exp_drop);
      e0 = 1'b0;
      e1 = 1'b0;
      if (clear_left > 0) begin
         clear_left--;
      end else if (CLEAR_EN && cs) begin
         clear_left = D;
         for (int unsigned i = 0; i < D; i++) begin
            w.due  = cyc + 2 + i;
            w.addr = AW'(i);
            w.data = cv;
            q.push_back(w);
         end
      end else if (v0 && v1) begin
         e0 = m_last;
         e1 = !m_last;
      end else begin
         e0 = v0;
         e1 = v1;
      end
      chk("ready0", r0, e0);
      chk("ready1", r1, e1);
      acc0 = e0;
      acc1 = e1;
      if (e0 || e1) begin
         m_last = e1;
         w.due  = cyc + 1;
         w.addr = e1 ? a1 : a0;
         w.data = e1 ? d1 : d0;
         if (w.addr < D) q.push_back(w);
         else if (exp_drop != 16'hFFFF) exp_drop++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      v0 = 1'b0; v1 = 1'b0; cs = 1'b0;
      q.delete();
      m_last = 1'b1;
      clear_left = 0;
      exp_drop = '0;
      @(negedge clk);
      chk("rst_ena", ena, 1'b0);
      chk("rst_wea", wea, 1'b0);
      chk("rst_addra", addra, 0);
      chk("rst_dia", dia, 0);
      chk("rst_drop", drop, 0);
      chk("rst_busy", busy, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   function automatic logic [AW-1:0] rand_addr();
      if ($urandom_range(0, 9) == 0) return AW'(D + $urandom_range(0, 100));
      return AW'($urandom_range(0, D - 1));
   endfunction

   initial begin
      do_reset();

      // Single req0 write
      v0 = 1'b1; a0 = AW'(5); d0 = 16'hABCD;
      step();
      v0 = 1'b0;
      repeat (3) step();

      // Both valid held: strict alternation starting with req0, no bubbles
      do_reset();
      v0 = 1'b1; a0 = AW'(10); d0 = 16'h1000;
      v1 = 1'b1; a1 = AW'(20); d1 = 16'h2000;
      repeat (6) begin
         step();
         if (acc0) begin a0 = a0 + AW'(1); d0 = d0 + W'(1); end
         if (acc1) begin a1 = a1 + AW'(1); d1 = d1 + W'(1); end
      end
      v0 = 1'b0; v1 = 1'b0;
      repeat (2) step();

      // Out-of-range address is accepted and dropped
      v1 = 1'b1; a1 = AW'(D); d1 = 16'h5555;
      step();
      v1 = 1'b0;
      repeat (2) step();

      // Randomized traffic with held addr/data until accepted
      for (int n = 0; n < 600; n++) begin
         if (!v0 || acc0) begin
            v0 = ($urandom_range(0, 3) != 0);
            a0 = rand_addr();
            d0 = W'($urandom);
         end
         if (!v1 || acc1) begin
            v1 = ($urandom_range(0, 3) != 0);
            a1 = rand_addr();
            d1 = W'($urandom);
         end
         cs = CLEAR_EN ? 1'b0 : ($urandom_range(0, 15) == 0);
         cv = W'($urandom);
         step();
      end
      v0 = 1'b0; v1 = 1'b0; cs = 1'b0;
      repeat (3) step();

`ifdef BRAM_CLEAR_EN
      // Full clear sweep while req0 waits; a mid-sweep start is ignored
      do_reset();
      v0 = 1'b1; a0 = AW'(7); d0 = 16'h1234;
      cs = 1'b1; cv = 16'h0000;
      step();
      cs = 1'b0;
      for (int unsigned i = 0; i < D; i++) begin
         cs = (i == 500);
         cv = 16'hFFFF;
         step();
      end
      cs = 1'b0;
      step();
      v0 = 1'b0;
      repeat (3) step();

      // Reset in the middle of a sweep leaves no residual sweep writes
      cs = 1'b1; cv = 16'hBEEF;
      step();
      cs = 1'b0;
      repeat (100) step();
      do_reset();
      v0 = 1'b1; a0 = AW'(42); d0 = 16'h4242;
      step();
      v0 = 1'b0;
      repeat (4) step();
`endif

      if (q.size() != 0) begin
         nvec++;
         nerr++;
         $display("FAIL scoreboard_drain: got %0d writes outstanding, expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
